// File: rtl/shifter_arbiter.sv
// -----------------------------------------------------------------------------
// shifter_arbiter
//   Shares one external barrel shifter between two requesters (A: ALU operand-2
//   path, B: load/store offset path). Requests are arbitrated round-robin,
//   issued through a registered sh_* interface, tracked by owner through a
//   LAT+1 deep pipe, and the result is returned as a registered one-cycle
//   response pulse to whichever port issued it. Latency from accept to
//   response is LAT+2 cycles. Timing disagreements between the owner pipe and
//   the shifter's result strobe, and reserved ops, set a sticky err flag.
//
// Ports
//   CP, reset                  clock (rising edge), synchronous active-low reset
//   a_*/b_* request            valid/ready handshake + op/data/num/cin fields
//   a_rsp_valid, b_rsp_valid   one-cycle result pulses per port
//   rsp_out, rsp_cout          shared result and carry, held between pulses
//   sh_valid/op/data/num/cin   registered issue interface to the shifter
//   sh_res_valid/out/cout      shifter result interface
//   busy                       any shift issued or in flight
//   err                        sticky protocol error
// -----------------------------------------------------------------------------
module shifter_arbiter #(
  parameter int DW  = 32,
  parameter int LAT = 1   // shifter latency, 1..4
) (
  input  logic          CP,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [2:0]    a_op,
  input  logic [DW-1:0] a_data,
  input  logic [7:0]    a_num,
  input  logic          a_cin,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [2:0]    b_op,
  input  logic [DW-1:0] b_data,
  input  logic [7:0]    b_num,
  input  logic          b_cin,
  output logic          a_rsp_valid,
  output logic          b_rsp_valid,
  output logic [DW-1:0] rsp_out,
  output logic          rsp_cout,
  output logic          sh_valid,
  output logic [2:0]    sh_op,
  output logic [DW-1:0] sh_data,
  output logic [7:0]    sh_num,
  output logic          sh_cin,
  input  logic          sh_res_valid,
  input  logic [DW-1:0] sh_out,
  input  logic          sh_cout,
  output logic          busy,
  output logic          err
);

  typedef enum logic { PORT_A = 1'b0, PORT_B = 1'b1 } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
  } own_t;

  // After reset, results of abandoned shifts may still arrive for up to LAT
  // cycles; unmatched strobes are ignored while this counter is non-zero.
  localparam logic [2:0] IGN_INIT = 3'(LAT + 1);

  port_e             ptr_q, ptr_d;
  logic              sh_valid_q, sh_valid_d;
  logic [2:0]        sh_op_q, sh_op_d;
  logic [DW-1:0]     sh_data_q, sh_data_d;
  logic [7:0]        sh_num_q, sh_num_d;
  logic              sh_cin_q, sh_cin_d;
  own_t [LAT:0]      pipe_q, pipe_d;
  logic              a_rsp_q, a_rsp_d;
  logic              b_rsp_q, b_rsp_d;
  logic [DW-1:0]     rsp_out_q, rsp_out_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              err_q, err_d;
  logic [2:0]        ign_q, ign_d;

  logic              grant_a, grant_b, grant;
  logic [2:0]        req_op;
  logic              reserved;
  logic              rsp_hit, unexpected, missing;
  logic              pipe_busy;
  own_t              tail;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_a    = a_valid & (~b_valid | (ptr_q == PORT_A));
    grant_b    = b_valid & (~a_valid | (ptr_q == PORT_B));
    grant      = grant_a | grant_b;

    ptr_d      = ptr_q;
    if (grant_a)      ptr_d = PORT_B;
    else if (grant_b) ptr_d = PORT_A;

    req_op     = grant_b ? b_op : a_op;
    reserved   = grant & (req_op > 3'd4);

    // Issue fields hold when nothing is granted; only sh_valid drops.
    sh_valid_d = grant;
    sh_op_d    = sh_op_q;
    sh_data_d  = sh_data_q;
    sh_num_d   = sh_num_q;
    sh_cin_d   = sh_cin_q;
    if (grant) begin
      sh_data_d = grant_b ? b_data : a_data;
      sh_cin_d  = grant_b ? b_cin  : a_cin;
      sh_num_d  = grant_b ? b_num  : a_num;
      sh_op_d   = req_op;
      if (reserved) begin
        // Reserved ops pass the operand through unchanged.
        sh_op_d  = 3'd0;
        sh_num_d = 8'd0;
      end
    end

    // Owner pipe entry 0 is loaded on the same edge as sh_valid, so entry
    // LAT lines up with the cycle the shifter result is due.
    pipe_d[0] = '{valid: grant, owner: (grant_b ? PORT_B : PORT_A)};
    for (int i = 1; i <= LAT; i++) pipe_d[i] = pipe_q[i-1];

    pipe_busy = 1'b0;
    for (int i = 0; i <= LAT; i++) pipe_busy = pipe_busy | pipe_q[i].valid;

    tail       = pipe_q[LAT];
    rsp_hit    = sh_res_valid & tail.valid;
    unexpected = sh_res_valid & ~tail.valid & (ign_q == 3'd0);
    missing    = tail.valid & ~sh_res_valid;

    a_rsp_d    = rsp_hit & (tail.owner == PORT_A);
    b_rsp_d    = rsp_hit & (tail.owner == PORT_B);
    rsp_out_d  = rsp_hit ? sh_out  : rsp_out_q;
    rsp_cout_d = rsp_hit ? sh_cout : rsp_cout_q;

    err_d      = err_q | unexpected | missing | reserved;
    ign_d      = (ign_q != 3'd0) ? ign_q - 3'd1 : 3'd0;
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge CP) begin
    if (!reset) begin
      ptr_q      <= PORT_A;
      sh_valid_q <= 1'b0;
      sh_op_q    <= '0;
      sh_data_q  <= '0;
      sh_num_q   <= '0;
      sh_cin_q   <= 1'b0;
      pipe_q     <= '0;
      a_rsp_q    <= 1'b0;
      b_rsp_q    <= 1'b0;
      rsp_out_q  <= '0;
      rsp_cout_q <= 1'b0;
      err_q      <= 1'b0;
      ign_q      <= IGN_INIT;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ptr_q      <= ptr_d;
      sh_valid_q <= sh_valid_d;
      sh_op_q    <= sh_op_d;
      sh_data_q  <= sh_data_d;
      sh_num_q   <= sh_num_d;
      sh_cin_q   <= sh_cin_d;
      pipe_q     <= pipe_d;
      a_rsp_q    <= a_rsp_d;
      b_rsp_q    <= b_rsp_d;
      rsp_out_q  <= rsp_out_d;
      rsp_cout_q <= rsp_cout_d;
      err_q      <= err_d;
      ign_q      <= ign_d;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign sh_valid    = sh_valid_q;
  assign sh_op       = sh_op_q;
  assign sh_data     = sh_data_q;
  assign sh_num      = sh_num_q;
  assign sh_cin      = sh_cin_q;
  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  assign rsp_out     = rsp_out_q;
  assign rsp_cout    = rsp_cout_q;
  assign busy        = sh_valid_q | pipe_busy;
  assign err         = err_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shifter_arbiter
//   Directed bench for shifter_arbiter. Two instances: u_dut1 (LAT=1) and
//   u_dut3 (LAT=3), each driven by a small behavioural shifter with the
//   matching latency. u_dut1's shifter has an extra strobe-injection input.
// -----------------------------------------------------------------------------
module tb_shifter_arbiter;

  logic CP = 1'b0;
  logic rst;
  initial forever #5 CP = ~CP;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- u_dut1 (LAT=1) ----------------
  logic        a_valid, a_ready, a_cin, b_valid, b_ready, b_cin;
  logic [2:0]  a_op, b_op, sh_op;
  logic [31:0] a_data, b_data, rsp_out, sh_data, sh_out;
  logic [7:0]  a_num, b_num, sh_num;
  logic        a_rsp, b_rsp, rsp_cout, sh_valid, sh_cin, sh_res_valid, sh_cout;
  logic        busy, err, inj1;
  logic        m1_v;
  logic [32:0] m1_res;

  shifter_arbiter #(.DW(32), .LAT(1)) u_dut1 (
    .CP(CP), .reset(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_data(a_data),
    .a_num(a_num), .a_cin(a_cin),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_data(b_data),
    .b_num(b_num), .b_cin(b_cin),
    .a_rsp_valid(a_rsp), .b_rsp_valid(b_rsp), .rsp_out(rsp_out), .rsp_cout(rsp_cout),
    .sh_valid(sh_valid), .sh_op(sh_op), .sh_data(sh_data), .sh_num(sh_num),
    .sh_cin(sh_cin), .sh_res_valid(sh_res_valid), .sh_out(sh_out), .sh_cout(sh_cout),
    .busy(busy), .err(err)
  );

  // ---------------- u_dut3 (LAT=3) ----------------
  logic        x_a_valid, x_a_ready, x_a_cin, x_b_valid, x_b_ready, x_b_cin;
  logic [2:0]  x_a_op, x_b_op, x_sh_op;
  logic [31:0] x_a_data, x_b_data, x_rsp_out, x_sh_data, x_sh_out;
  logic [7:0]  x_a_num, x_b_num, x_sh_num;
  logic        x_a_rsp, x_b_rsp, x_rsp_cout, x_sh_valid, x_sh_cin, x_sh_res_valid, x_sh_cout;
  logic        x_busy, x_err;
  logic        m3_v   [3];
  logic [32:0] m3_res [3];

  shifter_arbiter #(.DW(32), .LAT(3)) u_dut3 (
    .CP(CP), .reset(rst),
    .a_valid(x_a_valid), .a_ready(x_a_ready), .a_op(x_a_op), .a_data(x_a_data),
    .a_num(x_a_num), .a_cin(x_a_cin),
    .b_valid(x_b_valid), .b_ready(x_b_ready), .b_op(x_b_op), .b_data(x_b_data),
    .b_num(x_b_num), .b_cin(x_b_cin),
    .a_rsp_valid(x_a_rsp), .b_rsp_valid(x_b_rsp), .rsp_out(x_rsp_out), .rsp_cout(x_rsp_cout),
    .sh_valid(x_sh_valid), .sh_op(x_sh_op), .sh_data(x_sh_data), .sh_num(x_sh_num),
    .sh_cin(x_sh_cin), .sh_res_valid(x_sh_res_valid), .sh_out(x_sh_out), .sh_cout(x_sh_cout),
    .busy(x_busy), .err(x_err)
  );

  // Behavioural shifter: returns {cout, out}.
  function automatic logic [32:0] shift_fn(input logic [2:0] op, input logic [31:0] d,
                                           input logic [7:0] n, input logic c);
    logic [32:0] t;
    t = {c, d};
    if (op == 3'd4) begin
      t = {d[0], c, d[31:1]};
    end else if (n != 8'd0 && n <= 8'd32) begin
      case (op)
        3'd0: t = {1'b0, d} << n;
        3'd1: begin t = {d, 1'b0} >> n; t = {t[0], t[32:1]}; end
        3'd2: begin t = 33'($signed({d, 1'b0}) >>> n); t = {t[0], t[32:1]}; end
        3'd3: begin t[31:0] = (d >> n[4:0]) | (d << (6'd32 - {1'b0, n[4:0]})); t[32] = t[31]; end
        default: t = {c, d};
      endcase
    end
    return t;
  endfunction

  always @(posedge CP) begin
    m1_v      <= sh_valid;
    m1_res    <= shift_fn(sh_op, sh_data, sh_num, sh_cin);
    m3_v[0]   <= x_sh_valid;
    m3_res[0] <= shift_fn(x_sh_op, x_sh_data, x_sh_num, x_sh_cin);
    for (int i = 1; i < 3; i++) begin
      m3_v[i]   <= m3_v[i-1];
      m3_res[i] <= m3_res[i-1];
    end
  end

  assign sh_res_valid   = m1_v | inj1;
  assign sh_out         = m1_res[31:0];
  assign sh_cout        = m1_res[32];
  assign x_sh_res_valid = m3_v[2];
  assign x_sh_out       = m3_res[2][31:0];
  assign x_sh_cout      = m3_res[2][32];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  initial begin
    rst = 1'b0; inj1 = 1'b0;
    a_valid = 0; a_op = 0; a_data = 0; a_num = 0; a_cin = 0;
    b_valid = 0; b_op = 0; b_data = 0; b_num = 0; b_cin = 0;
    x_a_valid = 0; x_a_op = 0; x_a_data = 0; x_a_num = 0; x_a_cin = 0;
    x_b_valid = 0; x_b_op = 0; x_b_data = 0; x_b_num = 0; x_b_cin = 0;
    m1_v = 0; m1_res = '0;
    for (int i = 0; i < 3; i++) begin m3_v[i] = 0; m3_res[i] = '0; end

    // ---- reset state ----
    tick(); tick();
    check1 ("rst_sh_valid", sh_valid, 1'b0);
    check1 ("rst_a_rsp",    a_rsp,    1'b0);
    check1 ("rst_b_rsp",    b_rsp,    1'b0);
    check32("rst_rsp_out",  rsp_out,  32'h0);
    check32("rst_sh_data",  sh_data,  32'h0);
    check1 ("rst_err",      err,      1'b0);
    check1 ("rst_busy",     busy,     1'b0);
    check1 ("rst_x_err",    x_err,    1'b0);
    rst = 1'b1;

    // ---- T1: A alone, pass-through LSL #0 ----
    a_valid = 1; a_op = 3'd0; a_data = 32'h70020402; a_num = 8'd0; a_cin = 0;
    #1;
    check1("t1_a_ready", a_ready, 1'b1);
    check1("t1_b_ready", b_ready, 1'b0);
    tick();
    a_valid = 0;
    check1 ("t1_sh_valid", sh_valid, 1'b1);
    check32("t1_sh_data",  sh_data,  32'h70020402);
    check1 ("t1_busy",     busy,     1'b1);
    tick();
    check1("t1_a_rsp_early", a_rsp,    1'b0);
    check1("t1_sh_valid_0",  sh_valid, 1'b0);
    tick();
    check1 ("t1_a_rsp",    a_rsp,    1'b1);
    check1 ("t1_b_rsp",    b_rsp,    1'b0);
    check32("t1_rsp_out",  rsp_out,  32'h70020402);
    check1 ("t1_rsp_cout", rsp_cout, 1'b0);
    tick();
    check1 ("t1_a_rsp_pulse", a_rsp,   1'b0);
    check32("t1_rsp_hold",    rsp_out, 32'h70020402);
    check1 ("t1_err",         err,     1'b0);

    // ---- T2: both ports every cycle for 6 cycles (pointer reset to A) ----
    rst = 1'b0; tick(); rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_valid = (k < 6); a_op = 3'd0; a_data = 32'h0000000F; a_num = 8'd4;
      b_valid = (k < 6); b_op = 3'd1; b_data = 32'hF0000000; b_num = 8'd4;
      #1;
      if (k < 6) begin
        check1("t2_a_ready", a_ready, (k % 2 == 0));
        check1("t2_b_ready", b_ready, (k % 2 == 1));
      end
      if (k >= 3 && k <= 8) begin
        check1 ("t2_a_rsp",   a_rsp,   ((k - 3) % 2 == 0));
        check1 ("t2_b_rsp",   b_rsp,   ((k - 3) % 2 == 1));
        check32("t2_rsp_out", rsp_out, ((k - 3) % 2 == 0) ? 32'h000000F0 : 32'h0F000000);
      end else begin
        check1("t2_a_rsp_idle", a_rsp, 1'b0);
        check1("t2_b_rsp_idle", b_rsp, 1'b0);
      end
      check1("t2_err", err, 1'b0);
      tick();
    end

    // ---- T3: LAT=3, four back-to-back B-only requests ----
    for (int k = 0; k < 11; k++) begin
      x_b_valid = (k < 4); x_b_op = 3'd1; x_b_data = 32'h100 << k; x_b_num = 8'd4;
      #1;
      if (k < 4) begin
        check1("t3_b_ready", x_b_ready, 1'b1);
        check1("t3_a_ready", x_a_ready, 1'b0);
      end
      check1("t3_b_rsp", x_b_rsp, (k >= 5 && k <= 8));
      check1("t3_a_rsp", x_a_rsp, 1'b0);
      if (k >= 5 && k <= 8) check32("t3_rsp_out", x_rsp_out, 32'h10 << (k - 5));
      check1("t3_err", x_err, 1'b0);
      tick();
    end

    // ---- T4: stray result strobe sets sticky err ----
    check1("t4_err_before", err, 1'b0);
    inj1 = 1'b1;
    tick();
    inj1 = 1'b0;
    check1("t4_err",   err,   1'b1);
    check1("t4_a_rsp", a_rsp, 1'b0);
    check1("t4_b_rsp", b_rsp, 1'b0);
    a_valid = 1; a_op = 3'd0; a_data = 32'h00000055; a_num = 8'd1;
    #1;
    check1("t4_a_ready", a_ready, 1'b1);
    tick();
    a_valid = 0;
    tick(); tick();
    check1 ("t4_a_rsp_ok",  a_rsp,   1'b1);
    check32("t4_rsp_out",   rsp_out, 32'h000000AA);
    check1 ("t4_err_stick", err,     1'b1);
    tick();

    // ---- T5: reset with two shifts in flight ----
    a_valid = 1; a_op = 3'd0; a_data = 32'h00000001; a_num = 8'd0;
    tick();
    a_valid = 0;
    b_valid = 1; b_op = 3'd0; b_data = 32'h00000002; b_num = 8'd0;
    #1;
    check1("t5_b_ready", b_ready, 1'b1);
    tick();
    b_valid = 0;
    check1("t5_busy_pre", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check1 ("t5_sh_valid", sh_valid, 1'b0);
    check32("t5_sh_data",  sh_data,  32'h0);
    check32("t5_sh_num",   32'(sh_num), 32'h0);
    check1 ("t5_a_rsp",    a_rsp,    1'b0);
    check1 ("t5_b_rsp",    b_rsp,    1'b0);
    check32("t5_rsp_out",  rsp_out,  32'h0);
    check1 ("t5_err",      err,      1'b0);
    check1 ("t5_busy",     busy,     1'b0);
    a_valid = 1; b_valid = 1;
    #1;
    check1("t5_ptr_a", a_ready, 1'b1);
    check1("t5_ptr_b", b_ready, 1'b0);
    a_valid = 0; b_valid = 0;
    tick();
    check1("t5_err_stale", err,   1'b0);
    check1("t5_a_stale",   a_rsp, 1'b0);
    check1("t5_b_stale",   b_rsp, 1'b0);
    check1("t5_busy_post", busy,  1'b0);

    // ---- T6: reserved op issued as pass-through ----
    a_valid = 1; a_op = 3'd6; a_data = 32'h12345678; a_num = 8'd5; a_cin = 0;
    #1;
    check1("t6_a_ready", a_ready, 1'b1);
    tick();
    a_valid = 0; a_op = 3'd0;
    check1 ("t6_sh_valid", sh_valid,    1'b1);
    check32("t6_sh_op",    32'(sh_op),  32'h0);
    check32("t6_sh_num",   32'(sh_num), 32'h0);
    check32("t6_sh_data",  sh_data,     32'h12345678);
    check1 ("t6_err",      err,         1'b1);
    tick(); tick();
    check1 ("t6_a_rsp",    a_rsp,   1'b1);
    check32("t6_rsp_out",  rsp_out, 32'h12345678);
    check1 ("t6_err_hold", err,     1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one barrel shifter between two requesters: port A (ALU operand-2 path) and port B (load/store offset path).
- Round-robin arbitration with valid/ready request handshake. Issues one shift per cycle to the shifter.
- Tracks ownership of in-flight shifts and routes each result back to its requester with a registered response.
- Flags a sticky error if the shifter's result timing disagrees with the expected latency.

Parameters:
- DW, 32, data width of operand and result.
- LAT, 1, fixed shifter latency in cycles from sh_valid to sh_res_valid; legal range 1..4.

Ports:
- CP  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-low reset.
- a_valid  input  1  port A request valid.
- a_ready  output  1  port A request accepted this cycle (combinational).
- a_op  input  3  shift op: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX; 5-7 reserved.
- a_data  input  DW  operand.
- a_num  input  8  shift amount.
- a_cin  input  1  carry-in.
- b_valid, b_ready, b_op, b_data, b_num, b_cin: same as port A, for port B.
- a_rsp_valid  output  1  one-cycle pulse: port A result valid.
- b_rsp_valid  output  1  one-cycle pulse: port B result valid.
- rsp_out  output  DW  result, shared by both ports.
- rsp_cout  output  1  carry-out, shared by both ports.
- sh_valid  output  1  issue strobe to shifter (registered).
- sh_op  output  3  to shifter (registered).
- sh_data  output  DW  to shifter (registered).
- sh_num  output  8  to shifter (registered).
- sh_cin  output  1  to shifter (registered).
- sh_res_valid  input  1  shifter result strobe.
- sh_out  input  DW  shifter result.
- sh_cout  input  1  shifter carry-out.
- busy  output  1  any shift in flight (issue register or owner pipe non-empty).
- err  output  1  sticky protocol error.

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; sh_* registers 0; owner pipe cleared; priority pointer = A; err = 0.
  - Any in-flight shift is abandoned. An sh_res_valid arriving after reset is ignored and does not set err.
- Arbitration is combinational each cycle:
  - Only one port valid: that port gets ready.
  - Both valid: the pointer's port gets ready.
  - On any grant, the pointer moves to the other port on the next edge. No grant: pointer holds.
  - At most one ready per cycle.
- Requesters hold their fields stable while valid && !ready. The arbiter never withdraws a grant once given in a cycle.
- Reserved op (5-7) is accepted but issued as LSL with num=0 (pass-through), and err is set.
- Issue timing: a request accepted in cycle t gives sh_valid=1 with registered fields in cycle t+1. sh_valid is 0 in any cycle following no grant.
- Owner tracking:
  - Shift register of LAT+1 entries, each {valid, owner}, pushed with sh_valid.
  - The entry reaching the tail is the expected result owner in cycle t+1+LAT.
- Response:
  - sh_res_valid && tail.valid: register sh_out/sh_cout into rsp_out/rsp_cout, and pulse a_rsp_valid or b_rsp_valid in cycle t+2+LAT.
  - Total latency, request accept to response = LAT+2 cycles.
  - rsp_out/rsp_cout hold their last value between pulses.
- Error conditions (err is sticky until reset; the response pulse is suppressed on a mismatch):
  - sh_res_valid with tail.valid==0.
  - tail.valid with sh_res_valid==0.
- Throughput: one accept per cycle sustained. Responses have no backpressure; requesters must accept the pulse.
- busy = sh_valid | any owner-pipe entry valid.

Test Plan:
- Reset, then A alone: a_op=0, a_data=0x70020402, a_num=0, a_cin=0, LAT=1.
  - a_ready same cycle; sh_valid next cycle; a_rsp_valid exactly 3 cycles after accept with rsp_out=0x70020402, rsp_cout=0; b_rsp_valid stays 0.
- A and B valid every cycle for 6 cycles, with A=LSL #4 of 0x0000000F and B=LSR #4 of 0xF0000000.
  - Grants alternate A,B,A,B,A,B; responses alternate with results 0x000000F0 and 0x0F000000; no gaps, err=0.
- Back-to-back B-only requests for 4 cycles with LAT=3: 4 consecutive b_rsp_valid pulses, 5 cycles after each accept, in order.
- Inject an sh_res_valid pulse with no prior issue: err=1 and stays 1 through later correct traffic until reset=0; no rsp pulse.
- Assert reset low for 1 cycle while 2 shifts are in flight:
  - All outputs 0 next cycle; pointer=A; the stale sh_res_valid is ignored (err=0, no rsp).
- Request with a_op=6, a_data=0x12345678: issued as pass-through; rsp_out=0x12345678; err=1.
